dpath_io: RTL and testbench
===========================

// Module: dpath_io
// PURPOSE
//  Parametrised accumulator datapath: AR, PC, DR, AC, IR and TR registers, E carry flag, internal word memory and a common bus.
//  Adds NCH byte-wide I/O channels, each with INPR/FGI and OUTR/FGO flags, valid/ready handshakes, IEN/R interrupt state and an int_req output.
//  Driven cycle by cycle by the external control sequencer; holds no decode state of its own.
// PARAMETERS
//  DW      16  data word width (DR, AC, IR, TR, memory words); >= 12
//  AW      12  address width (AR, PC); memory depth = 2**AW; AW < DW
//  NCH     2   number of I/O channels, 1..8
//  PC_INIT 0   PC value after reset
// PORTS
//  clock      in   1       single clock, all state updates on rising edge
//  reset      in   1       synchronous, active-high
//  reg_ld     in   6       per-register load, bit index = REG_* id (AR0 PC1 DR2 AC3 IR4 TR5)
//  reg_clr    in   6       per-register clear
//  reg_inc    in   6       per-register increment
//  bus_sel    in   3       0 zero, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM
//  alu_op     in   3       ALU_* code, result loads AC when reg_ld[AC]
//  e_clr      in   1       clear E
//  e_cmp      in   1       complement E
//  mem_wr     in   1       write bus to mem[AR]
//  ien_set    in   1       set IEN
//  ien_clr    in   1       clear IEN
//  r_set      in   1       set R
//  r_clr      in   1       clear R
//  io_ch      in   3       channel select for inp_ack/out_ld
//  inp_ack    in   1       AC[7:0] <= INPR[io_ch], clear FGI[io_ch]
//  out_ld     in   1       OUTR[io_ch] <= AC[7:0], clear FGO[io_ch]
//  in_data    in   8*NCH   channel input bytes
//  in_valid   in   NCH     producer has a byte
//  in_ready   out  NCH     = ~FGI
//  out_data   out  8*NCH   OUTR contents
//  out_valid  out  NCH     = ~FGO
//  out_ready  in   NCH     consumer accepts byte
//  ac_out     out  DW      AC;  ir_out out DW IR;  ar_out out AW;  pc_out out AW
//  e_out      out  1       E flag
//  ac_neg     out  1       AC[DW-1];  ac_zero out 1 AC==0;  dr_zero out 1 DR==0
//  fgi        out  NCH     input flags;  fgo out NCH output flags
//  ien_out    out  1       IEN;  r_out out 1 R
//  int_req    out  1       IEN & (|FGI | |FGO)
// BEHAVIOUR
//  - Reset: AR DR AC IR TR =0, PC=PC_INIT, E=0, IEN=0, R=0, INPR=OUTR=0, FGI=0, FGO=all 1; memory not cleared; reset beats all controls.
//  - Per register priority: clr > ld > inc; inc wraps modulo 2**width. AR/PC load bus[AW-1:0]; AR/PC on bus zero-extended.
//  - Bus is combinational; MEM source = mem[AR] read asynchronously. mem_wr writes bus at edge; same-cycle MEM read returns old word.
//  - ALU: AND AC&DR; ADD {E,AC}<=AC+DR (carry to E); LDR AC<=DR; CMA ~AC; CIR {AC,E} rotate right; CIL rotate left; INP byte path (internal); PASS AC. E updated only by ADD/CIR/CIL with reg_ld[AC]; e_clr/e_cmp beat ALU E update.
//  - inp_ack: AC<={AC[DW-1:8],INPR[io_ch]}, FGI[io_ch]<=0; overrides reg_ld[AC] that cycle. io_ch >= NCH: no effect.
//  - Input handshake: in_valid&in_ready -> INPR<=in_data, FGI<=1. Same-cycle inp_ack on set FGI: FGI cleared, in_ready was 0 so no capture.
//  - Output: out_ld -> OUTR, FGO<=0; out_valid&out_ready -> FGO<=1, OUTR held. out_ld while out_valid=1 overwrites OUTR (sequencer must test FGO first).
//  - IEN/R: set beats clr. int_req combinational, no latency.
// STRUCTURE
//  - Package dpath_io_pkg: REG_* ids, BUS_* and ALU_* codes, IO_BYTE=8.
//  - Sub-module io_chan (one INPR/FGI/OUTR/FGO channel), generated NCH times; ALU stays inline.
// TESTING
//  1. Reset with PC_INIT=12'h100 -> pc_out=100, fgo=2'b11, fgi=0, int_req=0; after ien_set -> int_req=1.
//  2. mem[5]=16'h8001, DR<=mem[5], AC=16'hFFFF, ALU ADD -> AC=16'h8000, E=1; then CIR -> AC=16'hC000, E=0.
//  3. ch1 in_valid, data 8'h5A -> fgi=2'b10, in_ready[1]=0; inp_ack io_ch=1 -> AC[7:0]=5A, fgi=0, upper AC kept.
//  4. AC=16'h0041, out_ld io_ch=0 -> out_data[7:0]=41, out_valid[0]=1; out_ready held 3 cycles late -> FGO[0]=1 on accept edge.
//  5. PC=12'hFFF, reg_inc[PC] and reg_clr[PC] together -> 0; reg_inc only -> wraps to 0.
//  6. Reset asserted mid in-handshake (in_valid high) -> FGI=0, INPR=0 that edge; capture resumes next cycle.

Source files
------------

// File: rtl/dpath_io_pkg.sv
// Shared identifiers for the dpath_io accumulator datapath: register ids,
// bus source codes, ALU operation codes and the I/O byte width.
package dpath_io_pkg;

    // Bit positions in reg_ld / reg_clr / reg_inc
    localparam int unsigned REG_AR = 0;
    localparam int unsigned REG_PC = 1;
    localparam int unsigned REG_DR = 2;
    localparam int unsigned REG_AC = 3;
    localparam int unsigned REG_IR = 4;
    localparam int unsigned REG_TR = 5;
    localparam int unsigned NREG   = 6;

    localparam int unsigned IO_BYTE = 8;

    typedef enum logic [2:0] {
        BUS_ZERO = 3'd0,
        BUS_AR   = 3'd1,
        BUS_PC   = 3'd2,
        BUS_DR   = 3'd3,
        BUS_AC   = 3'd4,
        BUS_IR   = 3'd5,
        BUS_TR   = 3'd6,
        BUS_MEM  = 3'd7
    } bus_sel_e;

    typedef enum logic [2:0] {
        ALU_AND  = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_LDR  = 3'd2,
        ALU_CMA  = 3'd3,
        ALU_CIR  = 3'd4,
        ALU_CIL  = 3'd5,
        ALU_INP  = 3'd6,
        ALU_PASS = 3'd7
    } alu_op_e;

    // Only these operations produce a new E value
    function automatic logic alu_writes_e(alu_op_e op);
        return (op == ALU_ADD) || (op == ALU_CIR) || (op == ALU_CIL);
    endfunction

endpackage

// File: rtl/dpath_io_io_chan.sv
// One byte-wide I/O channel: INPR with its FGI flag on the input side,
// OUTR with its FGO flag on the output side, each with a valid/ready port.
module io_chan
    import dpath_io_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IO_BYTE-1:0] in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               inp_ack_i,
    input  logic               out_ld_i,
    input  logic [IO_BYTE-1:0] ac_byte_i,
    output logic [IO_BYTE-1:0] out_data_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [IO_BYTE-1:0] inpr_o,
    output logic               fgi_o,
    output logic               fgo_o
);

    logic [IO_BYTE-1:0] inpr_q, inpr_d;
    logic [IO_BYTE-1:0] outr_q, outr_d;
    logic               fgi_q, fgi_d;
    logic               fgo_q, fgo_d;

    // Next-state for both flag/buffer pairs
    always_comb begin
        inpr_d = inpr_q;
        fgi_d  = fgi_q;
        outr_d = outr_q;
        fgo_d  = fgo_q;

        // A capture only happens while FGI is clear, so an acknowledge of a
        // full buffer can never collide with a capture in the same cycle.
        if (in_valid_i && !fgi_q) begin
            inpr_d = in_data_i;
            fgi_d  = 1'b1;
        end else if (inp_ack_i) begin
            fgi_d = 1'b0;
        end

        if (out_ld_i) begin
            outr_d = ac_byte_i;
            fgo_d  = 1'b0;
        end else if (!fgo_q && out_ready_i) begin
            fgo_d = 1'b1;
        end
    end

    // Channel state registers, FGO idles high (output buffer empty)
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inpr_q <= '0;
            fgi_q  <= 1'b0;
            outr_q <= '0;
            fgo_q  <= 1'b1;
        end else begin
            inpr_q <= inpr_d;
            fgi_q  <= fgi_d;
            outr_q <= outr_d;
            fgo_q  <= fgo_d;
        end
    end

    assign in_ready_o  = ~fgi_q;
    assign out_valid_o = ~fgo_q;
    assign out_data_o  = outr_q;
    assign inpr_o      = inpr_q;
    assign fgi_o       = fgi_q;
    assign fgo_o       = fgo_q;

endmodule

// File: rtl/dpath_io.sv
// Accumulator datapath with common bus, word memory, inline ALU, E flag,
// interrupt enable state and NCH generated byte I/O channels. All control
// comes cycle by cycle from an external sequencer.
module dpath_io
    import dpath_io_pkg::*;
#(
    parameter int unsigned   DW      = 16,
    parameter int unsigned   AW      = 12,
    parameter int unsigned   NCH     = 2,
    parameter logic [AW-1:0] PC_INIT = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREG-1:0]      reg_ld,
    input  logic [NREG-1:0]      reg_clr,
    input  logic [NREG-1:0]      reg_inc,
    input  logic [2:0]           bus_sel,
    input  logic [2:0]           alu_op,
    input  logic                 e_clr,
    input  logic                 e_cmp,
    input  logic                 mem_wr,
    input  logic                 ien_set,
    input  logic                 ien_clr,
    input  logic                 r_set,
    input  logic                 r_clr,
    input  logic [2:0]           io_ch,
    input  logic                 inp_ack,
    input  logic                 out_ld,
    input  logic [8*NCH-1:0]     in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [8*NCH-1:0]     out_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [DW-1:0]        ac_out,
    output logic [DW-1:0]        ir_out,
    output logic [AW-1:0]        ar_out,
    output logic [AW-1:0]        pc_out,
    output logic                 e_out,
    output logic                 ac_neg,
    output logic                 ac_zero,
    output logic                 dr_zero,
    output logic [NCH-1:0]       fgi,
    output logic [NCH-1:0]       fgo,
    output logic                 ien_out,
    output logic                 r_out,
    output logic                 int_req
);

    logic [AW-1:0] ar_q, ar_d, pc_q, pc_d;
    logic [DW-1:0] dr_q, dr_d, ac_q, ac_d, ir_q, ir_d, tr_q, tr_d;
    logic          e_q, e_d;
    logic          ien_q, ien_d, r_q, r_d;

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] mem_rd;
    logic [DW-1:0] bus;

    logic [DW-1:0] alu_res;
    logic          alu_e;
    alu_op_e       op;

    logic [IO_BYTE-1:0] inpr_a [NCH];
    logic [IO_BYTE-1:0] inpr_sel;
    logic [NCH-1:0]     ack_v;
    logic [NCH-1:0]     ld_v;
    logic               inp_hit;
    logic               ac_ld_eff;

    assign op     = alu_op_e'(alu_op);
    assign mem_rd = mem_q[ar_q];

    // Common bus source select; AR/PC zero-extended
    always_comb begin
        bus = '0;
        case (bus_sel_e'(bus_sel))
            BUS_ZERO: bus = '0;
            BUS_AR:   bus = DW'(ar_q);
            BUS_PC:   bus = DW'(pc_q);
            BUS_DR:   bus = dr_q;
            BUS_AC:   bus = ac_q;
            BUS_IR:   bus = ir_q;
            BUS_TR:   bus = tr_q;
            BUS_MEM:  bus = mem_rd;
            default:  bus = '0;
        endcase
    end

    // Channel byte selected by io_ch; unselected codes read as zero
    always_comb begin
        inpr_sel = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (io_ch == 3'(i)) inpr_sel = inpr_a[i];
        end
    end

    assign inp_hit   = |ack_v;
    assign ac_ld_eff = reg_ld[REG_AC] & ~reg_clr[REG_AC] & ~inp_hit;

    // ALU result and carry/rotate output
    always_comb begin
        alu_res = ac_q;
        alu_e   = e_q;
        case (op)
            ALU_AND:  alu_res = ac_q & dr_q;
            ALU_ADD:  {alu_e, alu_res} = {1'b0, ac_q} + {1'b0, dr_q};
            ALU_LDR:  alu_res = dr_q;
            ALU_CMA:  alu_res = ~ac_q;
            ALU_CIR:  {alu_res, alu_e} = {e_q, ac_q};
            ALU_CIL:  {alu_e, alu_res} = {ac_q, e_q};
            ALU_INP:  alu_res = {ac_q[DW-1:IO_BYTE], inpr_sel};
            ALU_PASS: alu_res = ac_q;
            default:  alu_res = ac_q;
        endcase
    end

    // Register next-state: clear beats load beats increment
    always_comb begin
        ar_d = ar_q;
        if (reg_clr[REG_AR])      ar_d = '0;
        else if (reg_ld[REG_AR])  ar_d = bus[AW-1:0];
        else if (reg_inc[REG_AR]) ar_d = ar_q + 1'b1;

        pc_d = pc_q;
        if (reg_clr[REG_PC])      pc_d = '0;
        else if (reg_ld[REG_PC])  pc_d = bus[AW-1:0];
        else if (reg_inc[REG_PC]) pc_d = pc_q + 1'b1;

        dr_d = dr_q;
        if (reg_clr[REG_DR])      dr_d = '0;
        else if (reg_ld[REG_DR])  dr_d = bus;
        else if (reg_inc[REG_DR]) dr_d = dr_q + 1'b1;

        ir_d = ir_q;
        if (reg_clr[REG_IR])      ir_d = '0;
        else if (reg_ld[REG_IR])  ir_d = bus;
        else if (reg_inc[REG_IR]) ir_d = ir_q + 1'b1;

        tr_d = tr_q;
        if (reg_clr[REG_TR])      tr_d = '0;
        else if (reg_ld[REG_TR])  tr_d = bus;
        else if (reg_inc[REG_TR]) tr_d = tr_q + 1'b1;

        // Input acknowledge takes the load slot of AC for that cycle
        ac_d = ac_q;
        if (reg_clr[REG_AC])      ac_d = '0;
        else if (inp_hit)         ac_d = {ac_q[DW-1:IO_BYTE], inpr_sel};
        else if (reg_ld[REG_AC])  ac_d = alu_res;
        else if (reg_inc[REG_AC]) ac_d = ac_q + 1'b1;

        e_d = e_q;
        if (e_clr)                                  e_d = 1'b0;
        else if (e_cmp)                             e_d = ~e_q;
        else if (ac_ld_eff && alu_writes_e(op))     e_d = alu_e;

        ien_d = ien_q;
        if (ien_set)      ien_d = 1'b1;
        else if (ien_clr) ien_d = 1'b0;

        r_d = r_q;
        if (r_set)      r_d = 1'b1;
        else if (r_clr) r_d = 1'b0;
    end

    // Datapath state registers, reset overrides every control
    always_ff @(posedge clock) begin
        if (reset) begin
            ar_q  <= '0;
            pc_q  <= PC_INIT;
            dr_q  <= '0;
            ac_q  <= '0;
            ir_q  <= '0;
            tr_q  <= '0;
            e_q   <= 1'b0;
            ien_q <= 1'b0;
            r_q   <= 1'b0;
        end else begin
            ar_q  <= ar_d;
            pc_q  <= pc_d;
            dr_q  <= dr_d;
            ac_q  <= ac_d;
            ir_q  <= ir_d;
            tr_q  <= tr_d;
            e_q   <= e_d;
            ien_q <= ien_d;
            r_q   <= r_d;
        end
    end

    // Word memory write; contents survive reset
    always_ff @(posedge clock) begin
        if (!reset && mem_wr) mem_q[ar_q] <= bus;
    end

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_ch
            assign ack_v[g] = inp_ack & (io_ch == 3'(g));
            assign ld_v[g]  = out_ld  & (io_ch == 3'(g));

            io_chan u_chan (
                .clk_i       (clock),
                .rst_i       (reset),
                .in_data_i   (in_data[g*8 +: 8]),
                .in_valid_i  (in_valid[g]),
                .in_ready_o  (in_ready[g]),
                .inp_ack_i   (ack_v[g]),
                .out_ld_i    (ld_v[g]),
                .ac_byte_i   (ac_q[IO_BYTE-1:0]),
                .out_data_o  (out_data[g*8 +: 8]),
                .out_valid_o (out_valid[g]),
                .out_ready_i (out_ready[g]),
                .inpr_o      (inpr_a[g]),
                .fgi_o       (fgi[g]),
                .fgo_o       (fgo[g])
            );
        end
    endgenerate

    assign ac_out  = ac_q;
    assign ir_out  = ir_q;
    assign ar_out  = ar_q;
    assign pc_out  = pc_q;
    assign e_out   = e_q;
    assign ac_neg  = ac_q[DW-1];
    assign ac_zero = (ac_q == '0);
    assign dr_zero = (dr_q == '0);
    assign ien_out = ien_q;
    assign r_out   = r_q;
    assign int_req = ien_q & ((|fgi) | (|fgo));

endmodule

// File: tb/tb_dpath_io.sv
// Scoreboard bench for dpath_io: expectations are queued alongside each
// stimulus cycle and checked one clock later against the DUT outputs.
module tb_dpath_io;
    import dpath_io_pkg::*;

    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 12;
    localparam int unsigned NCH = 2;

    logic           clock = 1'b0;
    logic           reset;
    logic [5:0]     reg_ld, reg_clr, reg_inc;
    logic [2:0]     bus_sel, alu_op, io_ch;
    logic           e_clr, e_cmp, mem_wr, ien_set, ien_clr, r_set, r_clr;
    logic           inp_ack, out_ld;
    logic [15:0]    in_data;
    logic [1:0]     in_valid, in_ready, out_valid, out_ready, fgi, fgo;
    logic [15:0]    out_data;
    logic [DW-1:0]  ac_out, ir_out;
    logic [AW-1:0]  ar_out, pc_out;
    logic           e_out, ac_neg, ac_zero, dr_zero, ien_out, r_out, int_req;

    dpath_io #(.DW(DW), .AW(AW), .NCH(NCH), .PC_INIT(12'h100)) dut (
        .clock(clock), .reset(reset),
        .reg_ld(reg_ld), .reg_clr(reg_clr), .reg_inc(reg_inc),
        .bus_sel(bus_sel), .alu_op(alu_op),
        .e_clr(e_clr), .e_cmp(e_cmp), .mem_wr(mem_wr),
        .ien_set(ien_set), .ien_clr(ien_clr), .r_set(r_set), .r_clr(r_clr),
        .io_ch(io_ch), .inp_ack(inp_ack), .out_ld(out_ld),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ac_out(ac_out), .ir_out(ir_out), .ar_out(ar_out), .pc_out(pc_out),
        .e_out(e_out), .ac_neg(ac_neg), .ac_zero(ac_zero), .dr_zero(dr_zero),
        .fgi(fgi), .fgo(fgo), .ien_out(ien_out), .r_out(r_out),
        .int_req(int_req)
    );

    always #5 clock = ~clock;

    typedef enum int {
        O_PC, O_AR, O_AC, O_IR, O_E, O_NEG, O_ZERO, O_FGI, O_FGO,
        O_INRDY, O_OUTV, O_OUTD, O_INT, O_IEN, O_R
    } obs_e;

    typedef struct {
        string       tag;
        obs_e        sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] obs(obs_e s);
        case (s)
            O_PC:    return 32'(pc_out);
            O_AR:    return 32'(ar_out);
            O_AC:    return 32'(ac_out);
            O_IR:    return 32'(ir_out);
            O_E:     return 32'(e_out);
            O_NEG:   return 32'(ac_neg);
            O_ZERO:  return 32'(ac_zero);
            O_FGI:   return 32'(fgi);
            O_FGO:   return 32'(fgo);
            O_INRDY: return 32'(in_ready);
            O_OUTV:  return 32'(out_valid);
            O_OUTD:  return 32'(out_data);
            O_INT:   return 32'(int_req);
            O_IEN:   return 32'(ien_out);
            O_R:     return 32'(r_out);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input obs_e sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    // Advance one clock, sample 1 ns after the edge, retire queued expectations
    task automatic cyc();
        exp_t e;
        @(posedge clock);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.sel), e.val);
        end
    endtask

    task automatic idle();
        reg_ld = '0; reg_clr = '0; reg_inc = '0;
        bus_sel = BUS_ZERO; alu_op = ALU_PASS; io_ch = '0;
        e_clr = 0; e_cmp = 0; mem_wr = 0;
        ien_set = 0; ien_clr = 0; r_set = 0; r_clr = 0;
        inp_ack = 0; out_ld = 0;
    endtask

    initial begin
        idle();
        in_data = '0; in_valid = '0; out_ready = '0;

        // Reset state
        reset = 1;
        push("rst_pc", O_PC, 32'h100);
        push("rst_fgo", O_FGO, 32'h3);
        push("rst_fgi", O_FGI, 32'h0);
        push("rst_int", O_INT, 32'h0);
        push("rst_ac", O_AC, 32'h0);
        push("rst_e", O_E, 32'h0);
        push("rst_outv", O_OUTV, 32'h0);
        push("rst_inrdy", O_INRDY, 32'h3);
        cyc();
        reset = 0;

        ien_set = 1;
        push("ien_int", O_INT, 32'h1);
        push("ien_on", O_IEN, 32'h1);
        cyc(); idle();
        r_set = 1; r_clr = 1;
        push("r_setwins", O_R, 32'h1);
        cyc(); idle();
        r_clr = 1;
        push("r_clr", O_R, 32'h0);
        cyc(); idle();

        // Build AR=5 and AC=8001, store to mem[5]
        for (int i = 0; i < 5; i++) begin
            reg_inc[REG_AR] = 1;
            if (i == 4) push("ar_inc", O_AR, 32'h5);
            cyc();
        end
        idle();
        reg_inc[REG_AC] = 1;
        push("ac_inc", O_AC, 32'h1);
        cyc(); idle();
        reg_ld[REG_AC] = 1; alu_op = ALU_CIR;
        push("cir1_ac", O_AC, 32'h0);
        push("cir1_e", O_E, 32'h1);
        cyc();
        push("cir2_ac", O_AC, 32'h8000);
        push("cir2_e", O_E, 32'h0);
        cyc(); idle();
        reg_inc[REG_AC] = 1;
        push("ac_8001", O_AC, 32'h8001);
        cyc(); idle();
        bus_sel = BUS_AC; mem_wr = 1;
        cyc(); idle();
        bus_sel = BUS_MEM; reg_ld[REG_DR] = 1; reg_ld[REG_IR] = 1;
        push("ir_mem", O_IR, 32'h8001);
        cyc(); idle();

        // AC=FFFF, ADD DR -> 8000 carry 1, then CIR -> C000 E=0
        reg_clr[REG_AC] = 1;
        cyc(); idle();
        reg_ld[REG_AC] = 1; alu_op = ALU_CMA;
        push("cma", O_AC, 32'hFFFF);
        cyc();
        alu_op = ALU_ADD;
        push("add_ac", O_AC, 32'h8000);
        push("add_e", O_E, 32'h1);
        cyc();
        alu_op = ALU_CIR;
        push("cir_ac", O_AC, 32'hC000);
        push("cir_e", O_E, 32'h0);
        push("cir_neg", O_NEG, 32'h1);
        push("cir_zero", O_ZERO, 32'h0);
        cyc();
        // CIL would carry out 1; e_clr has priority over the ALU
        alu_op = ALU_CIL; e_clr = 1;
        push("cil_ac", O_AC, 32'h8000);
        push("cil_eclr", O_E, 32'h0);
        cyc(); idle();

        // Channel 1 input capture and acknowledge
        in_data = 16'h5A00; in_valid = 2'b10;
        push("in1_fgi", O_FGI, 32'h2);
        push("in1_rdy", O_INRDY, 32'h1);
        cyc();
        in_valid = '0;
        inp_ack = 1; io_ch = 3'd1;
        push("ack1_ac", O_AC, 32'h805A);
        push("ack1_fgi", O_FGI, 32'h0);
        cyc(); idle();

        // AC=0041 via channel 0, then output on channel 0
        reg_clr[REG_AC] = 1;
        in_data = 16'h0041; in_valid = 2'b01;
        push("in0_fgi", O_FGI, 32'h1);
        cyc(); idle();
        in_valid = '0;
        inp_ack = 1; io_ch = 3'd0;
        push("ack0_ac", O_AC, 32'h0041);
        cyc(); idle();
        out_ld = 1; io_ch = 3'd0;
        push("outld_data", O_OUTD, 32'h0041);
        push("outld_valid", O_OUTV, 32'h1);
        push("outld_fgo", O_FGO, 32'h2);
        cyc(); idle();
        for (int i = 0; i < 3; i++) begin
            push("out_hold", O_OUTV, 32'h1);
            cyc();
        end
        out_ready = 2'b01;
        push("out_acc_fgo", O_FGO, 32'h3);
        push("out_acc_valid", O_OUTV, 32'h0);
        push("out_acc_data", O_OUTD, 32'h0041);
        cyc();
        out_ready = '0;
        ien_clr = 1;
        push("ienclr_int", O_INT, 32'h0);
        cyc(); idle();
        ien_set = 1; ien_clr = 1;
        push("ien_setwins", O_INT, 32'h1);
        cyc(); idle();

        // PC wrap and priorities
        reg_clr[REG_AC] = 1;
        cyc(); idle();
        reg_ld[REG_AC] = 1; alu_op = ALU_CMA;
        cyc(); idle();
        bus_sel = BUS_AC; reg_ld[REG_PC] = 1;
        push("pc_ld", O_PC, 32'hFFF);
        cyc(); idle();
        reg_inc[REG_PC] = 1; reg_clr[REG_PC] = 1;
        push("pc_clrinc", O_PC, 32'h0);
        cyc(); idle();
        bus_sel = BUS_AC; reg_ld[REG_PC] = 1;
        cyc(); idle();
        reg_inc[REG_PC] = 1;
        push("pc_wrap", O_PC, 32'h0);
        cyc(); idle();
        bus_sel = BUS_AC; reg_ld[REG_PC] = 1; reg_inc[REG_PC] = 1;
        push("pc_ldinc", O_PC, 32'hFFF);
        cyc(); idle();

        // Reset during an input handshake
        in_data = 16'h0077; in_valid = 2'b01; reset = 1;
        push("rst_hs_fgi", O_FGI, 32'h0);
        push("rst_hs_pc", O_PC, 32'h100);
        push("rst_hs_ac", O_AC, 32'h0);
        cyc();
        reset = 0;
        push("post_rst_fgi", O_FGI, 32'h1);
        push("post_rst_rdy", O_INRDY, 32'h2);
        cyc();
        in_valid = '0;
        inp_ack = 1; io_ch = 3'd3;
        push("badch_fgi", O_FGI, 32'h1);
        push("badch_ac", O_AC, 32'h0);
        cyc(); idle();
        in_valid = 2'b01;
        inp_ack = 1; io_ch = 3'd0; reg_ld[REG_AC] = 1; alu_op = ALU_CMA;
        push("ackovr_ac", O_AC, 32'h0077);
        push("ackovr_fgi", O_FGI, 32'h0);
        cyc(); idle();
        push("recap_fgi", O_FGI, 32'h1);
        cyc();
        in_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
